// File: rtl/game_pkg.sv
// Shared types and constants for the 3x3 game turn controller.
package game_pkg;

    typedef enum logic [2:0] {
        P1_WAIT,
        P2_WAIT,
        AI_WAIT,
        PLACE,
        CHECK,
        OVER
    } state_e;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    localparam int unsigned NUM_CELLS  = 9;
    localparam int unsigned CELL_IDX_W = 4;

    function automatic logic [CELL_IDX_W-1:0] onehot_to_idx(input logic [NUM_CELLS-1:0] oh);
        logic [CELL_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (oh[i]) idx = CELL_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/first_free_cell.sv
// Combinational priority encoder: lowest-index free cell and an any-free flag.
module first_free_cell
    import game_pkg::*;
(
    input  logic [NUM_CELLS-1:0]  occupied_i,
    output logic [CELL_IDX_W-1:0] idx_o,
    output logic                  any_free_o
);

    always_comb begin
        idx_o      = '0;
        any_free_o = 1'b0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (!any_free_o && !occupied_i[i]) begin
                idx_o      = CELL_IDX_W'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Turn controller: arbitrates human buttons and the AI engine, emits one
// placement strobe per turn and evaluates end-of-game.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned AI_TIMEOUT = 15,
    parameter int unsigned TMR_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CELLS-1:0]  btn,
    input  logic                  ai_mode,
    input  logic [NUM_CELLS-1:0]  cell_occupied,
    input  logic                  p1_win,
    input  logic                  p2_win,
    input  logic                  grid_full,
    output logic                  ai_req,
    input  logic                  ai_move_valid,
    input  logic [CELL_IDX_W-1:0] ai_move,
    output logic                  place_valid,
    output logic [CELL_IDX_W-1:0] place_idx,
    output logic                  place_player,
    output logic                  turn_p1,
    output logic                  turn_p2,
    output logic                  game_over,
    output logic                  illegal
);

    state_e                state_q, state_d;
    logic                  player_q, player_d;
    logic [CELL_IDX_W-1:0] idx_q, idx_d;
    logic [NUM_CELLS-1:0]  btn_q;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  illegal_d;

    logic                  ai_req_q, place_valid_q, place_player_q;
    logic                  turn_p1_q, turn_p2_q, game_over_q, illegal_q;

    logic [NUM_CELLS-1:0]  press;
    logic                  multi_press;
    logic                  ai_ok;
    logic [CELL_IDX_W-1:0] ff_idx;
    logic                  any_free;

    first_free_cell u_first_free_cell (
        .occupied_i (cell_occupied),
        .idx_o      (ff_idx),
        .any_free_o (any_free)
    );

    always_comb begin
        press       = btn & ~btn_q;
        multi_press = (press & (press - 1'b1)) != '0;
        ai_ok       = (ai_move < CELL_IDX_W'(NUM_CELLS)) &&
                      ((cell_occupied & (NUM_CELLS'(1) << ai_move)) == '0);
    end

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        idx_d     = idx_q;
        timer_d   = '0;
        illegal_d = 1'b0;
        case (state_q)
            P1_WAIT, P2_WAIT: begin
                if (press != '0) begin
                    if (multi_press || ((press & cell_occupied) != '0)) begin
                        illegal_d = 1'b1;
                    end else begin
                        idx_d   = onehot_to_idx(press);
                        state_d = PLACE;
                    end
                end
            end
            AI_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A full board has nothing to place; CHECK routes it to OVER.
                if (!any_free) begin
                    state_d = CHECK;
                end else if (ai_move_valid) begin
                    state_d = PLACE;
                    if (ai_ok) begin
                        idx_d = ai_move;
                    end else begin
                        idx_d     = ff_idx;
                        illegal_d = 1'b1;
                    end
                end else if (timer_q == TMR_W'(AI_TIMEOUT - 1)) begin
                    idx_d   = ff_idx;
                    state_d = PLACE;
                end
            end
            PLACE: state_d = CHECK;
            CHECK: begin
                if (p1_win || p2_win || grid_full) begin
                    state_d = OVER;
                end else if (player_q == PLAYER_1) begin
                    player_d = PLAYER_2;
                    state_d  = ai_mode ? AI_WAIT : P2_WAIT;
                end else begin
                    player_d = PLAYER_1;
                    state_d  = P1_WAIT;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = P1_WAIT;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= P1_WAIT;
            player_q       <= PLAYER_1;
            idx_q          <= '0;
            btn_q          <= btn;
            timer_q        <= '0;
            ai_req_q       <= 1'b0;
            place_valid_q  <= 1'b0;
            place_player_q <= 1'b0;
            turn_p1_q      <= 1'b1;
            turn_p2_q      <= 1'b0;
            game_over_q    <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            player_q       <= player_d;
            idx_q          <= idx_d;
            btn_q          <= btn;
            timer_q        <= timer_d;
            ai_req_q       <= (state_d == AI_WAIT);
            place_valid_q  <= (state_d == PLACE);
            place_player_q <= (state_d == PLACE) && (player_d == PLAYER_2);
            turn_p1_q      <= (state_d == P1_WAIT) ||
                              (((state_d == PLACE) || (state_d == CHECK)) && (player_d == PLAYER_1));
            turn_p2_q      <= (state_d == P2_WAIT) || (state_d == AI_WAIT) ||
                              (((state_d == PLACE) || (state_d == CHECK)) && (player_d == PLAYER_2));
            game_over_q    <= (state_d == OVER);
            illegal_q      <= illegal_d;
        end
    end

    assign ai_req       = ai_req_q;
    assign place_valid  = place_valid_q;
    assign place_idx    = idx_q;
    assign place_player = place_player_q;
    assign turn_p1      = turn_p1_q;
    assign turn_p2      = turn_p2_q;
    assign game_over    = game_over_q;
    assign illegal      = illegal_q;

endmodule
